// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_pkg;

    localparam int INSTR_W = 24;
    localparam int PC_W    = 8;
    localparam int OPC_HI  = 23;
    localparam int OPC_LO  = 22;

    localparam logic [1:0] BR_CLASS      = 2'b11;
    localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_BRWAIT
    } state_t;

    function automatic logic is_branch(input logic [INSTR_W-1:0] word);
        return word[OPC_HI:OPC_LO] == BR_CLASS;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_counter.sv
// rtl/instruction_fetch_pc_counter.sv - program counter with load and wrapping increment
module pc_counter
    import instruction_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_next_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // pc_next_o lets the fetch FSM register the next request address in the same edge
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch FSM: request, wait with timeout, issue, branch resolve
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic [PC_W-1:0]    mem_addr,
    output logic               mem_req,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               mem_valid,
    output logic [INSTR_W-1:0] code,
    output logic               code_valid,
    input  logic               stall,
    input  logic               br_done,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic [PC_W-1:0]    pc
);

    state_t             state_q;
    logic [PC_W-1:0]    mem_addr_q;
    logic               mem_req_q;
    logic [INSTR_W-1:0] code_q;
    logic               code_valid_q;
    logic [3:0]         tmo_q;
    logic [3:0]         tmo_d;

    logic               pc_load;
    logic               pc_inc;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;

    always_comb begin
        pc_inc  = (state_q == S_ISSUE) && !stall;
        pc_load = (state_q == S_BRWAIT) && br_done && br_taken;
        tmo_d   = tmo_q + 4'd1;
    end

    pc_counter u_pc_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .load_val_i (br_target),
        .inc_i      (pc_inc),
        .pc_o       (pc_q),
        .pc_next_o  (pc_d)
    );

    // Outputs are registered on entry to a state, so the request address uses pc_d
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mem_req_q    <= 1'b0;
                    code_valid_q <= 1'b0;
                    if (enable) begin
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_d;
                    end
                end
                S_REQ: begin
                    mem_req_q <= 1'b0;
                    tmo_q     <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        code_q       <= mem_data;
                        code_valid_q <= 1'b1;
                        tmo_q        <= '0;
                        state_q      <= S_ISSUE;
                    end else if (tmo_d == TIMEOUT_LIMIT) begin
                        tmo_q      <= '0;
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                    end else begin
                        tmo_q <= tmo_d;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        code_valid_q <= 1'b0;
                        if (is_branch(code_q)) begin
                            state_q <= S_BRWAIT;
                        end else if (enable) begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_d;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_BRWAIT: begin
                    if (br_done) begin
                        if (enable) begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_d;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    mem_req_q    <= 1'b0;
                    code_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_req    = mem_req_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst, enable, mem_req, mem_valid, code_valid, stall, br_done, br_taken;
    logic [7:0]  mem_addr, br_target, pc;
    logic [23:0] mem_data, code;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_ISSUE = 3, PH_BR = 4;
    int          ph;
    int          m_pc, m_addr, waited;
    logic [23:0] m_code;

    instruction_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .code       (code),
        .code_valid (code_valid),
        .stall      (stall),
        .br_done    (br_done),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: where the fetch is in its life cycle, what was last requested, what is held
    always @(posedge clk) begin
        if (rst) begin
            ph = PH_IDLE; m_pc = 0; m_addr = 0; m_code = '0; waited = 0;
        end else begin
            case (ph)
                PH_IDLE: if (enable) begin ph = PH_REQ; m_addr = m_pc; end
                PH_REQ: begin ph = PH_WAIT; waited = 0; end
                PH_WAIT: begin
                    if (mem_valid) begin
                        m_code = mem_data; ph = PH_ISSUE;
                    end else begin
                        waited = waited + 1;
                        if (waited == 15) begin ph = PH_REQ; m_addr = m_pc; end
                    end
                end
                PH_ISSUE: if (!stall) begin
                    m_pc = (m_pc + 1) % 256;
                    if (m_code[23:22] == 2'b11) ph = PH_BR;
                    else if (enable) begin ph = PH_REQ; m_addr = m_pc; end
                    else ph = PH_IDLE;
                end
                PH_BR: if (br_done) begin
                    if (br_taken) m_pc = int'(br_target);
                    if (enable) begin ph = PH_REQ; m_addr = m_pc; end
                    else ph = PH_IDLE;
                end
                default: ph = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req",    32'(mem_req),    32'(ph == PH_REQ));
            chk("mem_addr",   32'(mem_addr),   32'(m_addr));
            chk("code",       32'(code),       32'(m_code));
            chk("code_valid", 32'(code_valid), 32'(ph == PH_ISSUE));
            chk("pc",         32'(pc),         32'(m_pc));
        end
    end

    task automatic cyc(input bit r, input bit e, input bit mv, input logic [23:0] md,
                       input bit st, input bit bd, input bit bt, input logic [7:0] tg);
        rst = r; enable = e; mem_valid = mv; mem_data = md;
        stall = st; br_done = bd; br_taken = bt; br_target = tg;
        @(negedge clk);
    endtask

    task automatic run(input bit e);
        cyc(0, e, 0, 24'h0, 0, 0, 0, 8'h0);
    endtask

    task automatic feed(input logic [23:0] md);
        cyc(0, 1, 1, md, 0, 0, 0, 8'h0);
    endtask

    int          cd;
    bit          r, e, mv, st, bd, bt;
    logic [23:0] md;
    logic [7:0]  tg;

    initial begin
        cyc(1, 0, 0, 24'h0, 0, 0, 0, 8'h0);
        chk_en = 1'b1;
        cyc(1, 0, 0, 24'h0, 0, 0, 0, 8'h0);
        chk("rst mem_addr", 32'(mem_addr), 32'h0);
        chk("rst mem_req", 32'(mem_req), 32'h0);
        chk("rst code", 32'(code), 32'h0);
        chk("rst code_valid", 32'(code_valid), 32'h0);
        chk("rst pc", 32'(pc), 32'h0);

        run(1);
        chk("first req", 32'(mem_req), 32'h1);
        chk("first addr", 32'(mem_addr), 32'h0);
        cyc(0, 1, 1, 24'hFFFFFF, 0, 0, 0, 8'h0);
        chk("req-cycle valid ignored", 32'(code), 32'h0);
        chk("req pulse one cycle", 32'(mem_req), 32'h0);
        feed(24'h000130);
        chk("issue code", 32'(code), 32'h000130);
        chk("issue valid", 32'(code_valid), 32'h1);
        run(0);
        chk("pc after issue", 32'(pc), 32'h1);
        chk("valid drops", 32'(code_valid), 32'h0);
        run(0);
        chk("parked idle", 32'(mem_req), 32'h0);

        run(1);
        chk("addr 1", 32'(mem_addr), 32'h1);
        run(1);
        feed(24'h000055);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 24'h0, 1, 0, 0, 8'h0);
            chk("stall code", 32'(code), 32'h000055);
            chk("stall valid", 32'(code_valid), 32'h1);
            chk("stall pc", 32'(pc), 32'h1);
        end
        run(1);
        chk("after stall addr", 32'(mem_addr), 32'h2);
        chk("after stall pc", 32'(pc), 32'h2);

        run(1);
        feed(24'hC00000);
        run(1);
        chk("brwait pc", 32'(pc), 32'h3);
        chk("brwait valid", 32'(code_valid), 32'h0);
        run(1);
        chk("brwait no req", 32'(mem_req), 32'h0);
        cyc(0, 1, 0, 24'h0, 0, 1, 1, 8'h40);
        chk("taken req", 32'(mem_req), 32'h1);
        chk("taken addr", 32'(mem_addr), 32'h40);
        run(1);
        feed(24'hC00000);
        run(1);
        cyc(0, 1, 0, 24'h0, 0, 1, 0, 8'h99);
        chk("not-taken addr", 32'(mem_addr), 32'h41);

        run(1);
        for (int k = 0; k < 14; k++) begin
            run(1);
            chk("timeout waiting", 32'(mem_req), 32'h0);
        end
        run(1);
        chk("timeout re-req", 32'(mem_req), 32'h1);
        chk("timeout same addr", 32'(mem_addr), 32'h41);
        run(1);
        feed(24'h000777);
        chk("late data", 32'(code), 32'h000777);

        run(1);
        run(1);
        feed(24'hC00000);
        run(1);
        cyc(0, 1, 0, 24'h0, 0, 1, 1, 8'hFF);
        chk("addr FF", 32'(mem_addr), 32'hFF);
        run(1);
        feed(24'h000001);
        run(1);
        chk("wrap addr", 32'(mem_addr), 32'h00);
        chk("wrap pc", 32'(pc), 32'h00);

        run(1);
        cyc(1, 1, 0, 24'h0, 0, 0, 0, 8'h0);
        cyc(0, 0, 1, 24'hABCDEF, 0, 1, 1, 8'h55);
        chk("post-rst code", 32'(code), 32'h0);
        chk("post-rst valid", 32'(code_valid), 32'h0);
        chk("post-rst req", 32'(mem_req), 32'h0);
        chk("post-rst pc", 32'(pc), 32'h0);

        cd = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 2) == 0);
            bd = ($urandom_range(0, 3) == 0);
            bt = 1'($urandom);
            tg = 8'($urandom);
            mv = ($urandom_range(0, 19) == 0);
            md = 24'($urandom);
            if (mem_req) begin
                cd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 17))
                                                 : int'($urandom_range(1, 4));
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) mv = 1'b1;
            end
            if (r) cd = 0;
            cyc(r, e, mv, md, st, bd, bt, tg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
